// File: rtl/ws2812_pkg.sv
// ws2812_pkg: FSM state codes, 16 MHz timing defaults and a ns-to-cycles helper for the WS2812 receiver
package ws2812_pkg;
    localparam int PIX_W  = 24;
    localparam int CLK_HZ = 16_000_000;

    localparam logic [1:0] S_SYNC = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_LOW  = 2'd3;

    function automatic int ns_to_cyc(input int ns);
        return int'((longint'(ns) * longint'(CLK_HZ) + 64'sd500_000_000) / 64'sd1_000_000_000);
    endfunction

    localparam int DEF_THRESH_CYC   = ns_to_cyc(625);
    localparam int DEF_LATCH_CYC    = ns_to_cyc(50_000);
    localparam int DEF_MIN_HIGH_CYC = 2;
    localparam int DEF_MAX_HIGH_CYC = 40;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: two-flop synchronizer for an async pin with registered level and edge pulses
module sync_edge (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);
    logic [1:0] meta;

    // lvl, rise and fall all describe the same synchronized sample, so they line up in time
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            {meta, lvl, rise, fall} <= '0;
        end else begin
            meta <= {meta[0], din};
            lvl  <= meta[1];
            rise <= meta[1] & ~lvl;
            fall <= ~meta[1] & lvl;
        end
endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: decodes a WS2812 NRZ stream into 24-bit GRB pixels with index, frame and error pulses
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int THRESH_CYC   = DEF_THRESH_CYC,
    parameter int MIN_HIGH_CYC = DEF_MIN_HIGH_CYC,
    parameter int MAX_HIGH_CYC = DEF_MAX_HIGH_CYC,
    parameter int LATCH_CYC    = DEF_LATCH_CYC,
    parameter int IDX_W        = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             DIN,
    output logic [PIX_W-1:0] PIX_DATA,
    output logic             PIX_VALID,
    output logic [IDX_W-1:0] PIX_IDX,
    output logic             FRAME_END,
    output logic             ERR,
    output logic             BUSY
);
    localparam int CW = $clog2(LATCH_CYC + 1);
    localparam logic [CW-1:0] THR    = CW'(THRESH_CYC);
    localparam logic [CW-1:0] MINH   = CW'(MIN_HIGH_CYC);
    localparam logic [CW-1:0] MAXH   = CW'(MAX_HIGH_CYC);
    localparam logic [CW-1:0] LAT_M1 = CW'(LATCH_CYC - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic             lvl, rise, fall;
    logic [1:0]       state;
    logic [CW-1:0]    hcnt, lcnt;
    logic [PIX_W-1:0] shreg, nxt_sh;
    logic [4:0]       bitcnt;
    logic [IDX_W-1:0] idx;
    logic             took;

    sync_edge u_sync (
        .CLK (CLK),
        .RST (RST),
        .din (DIN),
        .lvl (lvl),
        .rise(rise),
        .fall(fall)
    );

    // hcnt equals the high length in cycles when the falling edge arrives; MSB arrives first
    always_comb nxt_sh = {shreg[PIX_W-2:0], hcnt >= THR};

    // pulse-width FSM: decode bits, assemble pixels, detect latch and protocol errors
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state     <= S_SYNC;
            hcnt      <= '0;
            lcnt      <= '0;
            shreg     <= '0;
            bitcnt    <= '0;
            idx       <= '0;
            took      <= 1'b0;
            PIX_DATA  <= '0;
            PIX_VALID <= 1'b0;
            PIX_IDX   <= '0;
            FRAME_END <= 1'b0;
            ERR       <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            PIX_VALID <= 1'b0;
            FRAME_END <= 1'b0;
            ERR       <= 1'b0;
            case (state)
                S_SYNC:
                    if (lvl) lcnt <= '0;
                    else if (lcnt == LAT_M1) begin
                        state <= S_IDLE;
                        lcnt  <= '0;
                    end else lcnt <= lcnt + ONE;
                S_IDLE:
                    if (rise) begin
                        state <= S_HIGH;
                        hcnt  <= ONE;
                        BUSY  <= 1'b1;
                    end
                S_HIGH:
                    if (hcnt > MAXH) begin
                        ERR    <= 1'b1;
                        state  <= S_SYNC;
                        lcnt   <= '0;
                        bitcnt <= '0;
                        idx    <= '0;
                        took   <= 1'b0;
                        BUSY   <= 1'b0;
                    end else if (fall) begin
                        state <= S_LOW;
                        lcnt  <= ONE;
                        if (hcnt < MINH) ERR <= 1'b1;
                        else begin
                            shreg <= nxt_sh;
                            took  <= 1'b1;
                            if (bitcnt == 5'd23) begin
                                PIX_DATA  <= nxt_sh;
                                PIX_VALID <= 1'b1;
                                PIX_IDX   <= idx;
                                idx       <= idx + 1'b1;
                                bitcnt    <= '0;
                            end else bitcnt <= bitcnt + 5'd1;
                        end
                    end else hcnt <= hcnt + ONE;
                S_LOW:
                    if (rise) begin
                        state <= S_HIGH;
                        hcnt  <= ONE;
                        lcnt  <= '0;
                    end else if (lcnt == LAT_M1) begin
                        state     <= S_IDLE;
                        lcnt      <= '0;
                        FRAME_END <= took;
                        ERR       <= |bitcnt;
                        bitcnt    <= '0;
                        idx       <= '0;
                        took      <= 1'b0;
                        BUSY      <= 1'b0;
                    end else lcnt <= lcnt + ONE;
            endcase
        end
endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: drives timed WS2812 pulses and checks decoded events against a pulse-length model
module tb_ws2812_rx;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        DIN = 1'b0;
    logic [23:0] PIX_DATA;
    logic        PIX_VALID;
    logic [7:0]  PIX_IDX;
    logic        FRAME_END, ERR, BUSY;

    ws2812_rx dut (
        .CLK      (CLK),
        .RST      (RST),
        .DIN      (DIN),
        .PIX_DATA (PIX_DATA),
        .PIX_VALID(PIX_VALID),
        .PIX_IDX  (PIX_IDX),
        .FRAME_END(FRAME_END),
        .ERR      (ERR),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        pv;
        logic [23:0] d;
        logic [7:0]  i;
        logic        fe;
        logic        er;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         got, want;
    int          vectors = 0, miscompares = 0;
    int          n_pix, n_fe, n_err, n_both;
    bit          first_seen;
    logic [23:0] first_d, last_d;
    logic [7:0]  last_i;

    // model: judges each pulse purely by its length in cycles
    bit          m_sync = 1'b1, m_took = 1'b0;
    int          m_bits = 0, m_idx = 0;
    logic [23:0] m_sh = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic void push(input logic pv, input logic [23:0] d, input logic [7:0] i, input logic fe, input logic er);
        ev_t e;
        e.pv = pv; e.d = d; e.i = i; e.fe = fe; e.er = er;
        exp_q.push_back(e);
    endfunction

    task automatic hi(input int n);
        if (!m_sync) begin
            if (n > 40) begin
                push(1'b0, 24'h0, 8'h0, 1'b0, 1'b1);
                m_sync = 1'b1; m_bits = 0; m_took = 1'b0; m_idx = 0;
            end else if (n < 2) push(1'b0, 24'h0, 8'h0, 1'b0, 1'b1);
            else begin
                m_sh   = {m_sh[22:0], n >= 10};
                m_took = 1'b1;
                m_bits++;
                if (m_bits == 24) begin
                    push(1'b1, m_sh, 8'(m_idx), 1'b0, 1'b0);
                    m_idx  = (m_idx + 1) % 256;
                    m_bits = 0;
                end
            end
        end
        DIN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic lo(input int n);
        if (n >= 800) begin
            if (!m_sync && m_took) push(1'b0, 24'h0, 8'h0, 1'b1, m_bits != 0);
            m_sync = 1'b0; m_bits = 0; m_took = 1'b0; m_idx = 0;
        end
        DIN = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    // bits top..bot of p; 0 uses h0 high, 1 uses h1 high, each bit period 20 cycles unless last_l overrides the final low
    task automatic px(input logic [23:0] p, input int top, input int bot, input int h0, input int h1, input int last_l);
        for (int k = top; k >= bot; k--) begin
            int h;
            h = p[k] ? h1 : h0;
            hi(h);
            lo((k == bot && last_l > 0) ? last_l : 20 - h);
        end
    endtask

    task automatic send_px(input logic [23:0] p);
        px(p, 23, 0, 6, 13, 0);
    endtask

    task automatic clr();
        n_pix = 0; n_fe = 0; n_err = 0; n_both = 0;
        first_seen = 1'b0; first_d = '0; last_d = '0; last_i = '0;
    endtask

    task automatic drain(input string name);
        repeat (5) @(negedge CLK);
        check(name, 64'(exp_q.size()), 64'(0));
    endtask

    // every cycle with any pulse must match the next event the model predicted
    always @(negedge CLK)
        if (!RST && (PIX_VALID || FRAME_END || ERR)) begin
            got.pv = PIX_VALID;
            got.d  = PIX_VALID ? PIX_DATA : 24'h0;
            got.i  = PIX_VALID ? PIX_IDX : 8'h0;
            got.fe = FRAME_END;
            got.er = ERR;
            if (exp_q.size() == 0) check("unexpected_event", 64'(got), 64'(0));
            else begin
                want = exp_q.pop_front();
                check("event", 64'(got), 64'(want));
            end
            if (PIX_VALID) begin
                n_pix++;
                last_d = PIX_DATA;
                last_i = PIX_IDX;
                if (!first_seen) begin
                    first_d    = PIX_DATA;
                    first_seen = 1'b1;
                end
            end
            if (FRAME_END) n_fe++;
            if (ERR) n_err++;
            if (FRAME_END && ERR) n_both++;
        end

    initial begin
        clr();
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        check("rst_data", 64'(PIX_DATA), 64'(0));
        check("rst_valid", 64'(PIX_VALID), 64'(0));
        check("rst_idx", 64'(PIX_IDX), 64'(0));
        check("rst_fe", 64'(FRAME_END), 64'(0));
        check("rst_err", 64'(ERR), 64'(0));
        check("rst_busy", 64'(BUSY), 64'(0));

        lo(900);
        send_px(24'hA5C31E);
        check("t1_busy_mid", 64'(BUSY), 64'(1));
        lo(900);
        drain("t1_drain");
        check("t1_npix", 64'(n_pix), 64'(1));
        check("t1_data", 64'(last_d), 64'h00A5C31E);
        check("t1_idx", 64'(last_i), 64'(0));
        check("t1_fe", 64'(n_fe), 64'(1));
        check("t1_busy_end", 64'(BUSY), 64'(0));

        clr();
        send_px(24'h000000);
        send_px(24'hFFFFFF);
        send_px(24'h123456);
        lo(900);
        drain("t2_drain");
        check("t2_npix", 64'(n_pix), 64'(3));
        check("t2_first", 64'(first_d), 64'h0);
        check("t2_last", 64'(last_d), 64'h00123456);
        check("t2_idx", 64'(last_i), 64'(2));
        check("t2_fe", 64'(n_fe), 64'(1));
        check("t2_err", 64'(n_err), 64'(0));

        clr();
        px(24'hF0F0F0, 23, 12, 6, 13, 0);
        lo(900);
        drain("t3a_drain");
        check("t3_npix", 64'(n_pix), 64'(0));
        check("t3_both", 64'(n_both), 64'(1));
        clr();
        send_px(24'h0F0F0F);
        lo(900);
        drain("t3b_drain");
        check("t3_idx", 64'(last_i), 64'(0));
        check("t3_data", 64'(last_d), 64'h000F0F0F);

        clr();
        px(24'h3C3C3C, 23, 19, 6, 13, 0);
        hi(1);
        lo(7);
        px(24'h3C3C3C, 18, 0, 6, 13, 0);
        px(24'hE00000, 23, 21, 6, 13, 0);
        hi(50);
        check("t4_busy_sync", 64'(BUSY), 64'(0));
        send_px(24'hFFFFFF);
        lo(900);
        send_px(24'h000001);
        lo(900);
        drain("t4_drain");
        check("t4_npix", 64'(n_pix), 64'(2));
        check("t4_glitch_px", 64'(first_d), 64'h003C3C3C);
        check("t4_last", 64'(last_d), 64'h00000001);
        check("t4_idx", 64'(last_i), 64'(0));
        check("t4_err", 64'(n_err), 64'(2));
        check("t4_fe", 64'(n_fe), 64'(1));

        clr();
        px(24'hABCDEF, 23, 14, 6, 13, 0);
        check("t5_busy", 64'(BUSY), 64'(1));
        drain("t5a_drain");
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        m_sync = 1'b1; m_bits = 0; m_took = 1'b0; m_idx = 0;
        check("t5_rst_data", 64'(PIX_DATA), 64'(0));
        check("t5_rst_busy", 64'(BUSY), 64'(0));
        px(24'hABCDEF, 13, 0, 6, 13, 0);
        send_px(24'h111111);
        lo(900);
        send_px(24'h654321);
        lo(900);
        drain("t5b_drain");
        check("t5_npix", 64'(n_pix), 64'(1));
        check("t5_data", 64'(last_d), 64'h00654321);
        check("t5_idx", 64'(last_i), 64'(0));
        check("t5_fe", 64'(n_fe), 64'(1));

        clr();
        px(24'h5A5A5A, 23, 0, 9, 10, 799);
        px(24'h00FF00, 23, 0, 6, 13, 800);
        lo(100);
        drain("t6_drain");
        check("t6_npix", 64'(n_pix), 64'(2));
        check("t6_thresh", 64'(first_d), 64'h005A5A5A);
        check("t6_nolatch_idx", 64'(last_i), 64'(1));
        check("t6_fe", 64'(n_fe), 64'(1));
        check("t6_err", 64'(n_err), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
